// File: rtl/riscv_dmem_arb_pkg.sv
// riscv_dmem_arb_pkg: shared data width and arbiter state encodings
package riscv_dmem_arb_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
endpackage

// File: rtl/riscv_dmem_arb_rsp.sv
// riscv_dmem_arb_rsp: per-master read response register (clk, rst, rd_en, mem_rd_data -> rd_valid, rd_data)
module riscv_dmem_arb_rsp
  import riscv_dmem_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [XLEN-1:0] mem_rd_data,
  output logic            rd_valid,
  output logic [XLEN-1:0] rd_data
);
  always_ff @(posedge clk)
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem_rd_data;
    end
endmodule

// File: rtl/riscv_dmem_arb.sv
// riscv_dmem_arb: round-robin M0/M1 data memory arbiter with bounded lock (mX_* master ports, mem_* dmem pins, clk/rst)
module riscv_dmem_arb
  import riscv_dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_lock,
  input  logic            m0_wr_en,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [3:0]      m0_byte_sel,
  input  logic [XLEN-1:0] m0_wr_data,
  output logic            m0_gnt,
  output logic            m0_rd_valid,
  output logic [XLEN-1:0] m0_rd_data,
  input  logic            m1_req,
  input  logic            m1_lock,
  input  logic            m1_wr_en,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [3:0]      m1_byte_sel,
  input  logic [XLEN-1:0] m1_wr_data,
  output logic            m1_gnt,
  output logic            m1_rd_valid,
  output logic [XLEN-1:0] m1_rd_data,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wr_en,
  output logic [3:0]      mem_byte_sel,
  output logic [XLEN-1:0] mem_wr_data,
  input  logic [XLEN-1:0] mem_rd_data
);
  localparam int CW = $clog2(MAX_LOCK);
  state_t        state;
  logic          last_gnt;
  logic [CW-1:0] lock_cnt;
  logic          sel;
  logic          own_lock;
  always_comb begin
    m0_gnt       = !rst && (state == IDLE ? m0_req && (!m1_req || last_gnt) : state == OWN0 && m0_req);
    m1_gnt       = !rst && (state == IDLE ? m1_req && (!m0_req || !last_gnt) : state == OWN1 && m1_req);
    sel          = m1_gnt || (!m0_gnt && last_gnt);
    mem_addr     = sel ? m1_addr : m0_addr;
    mem_byte_sel = sel ? m1_byte_sel : m0_byte_sel;
    mem_wr_data  = sel ? m1_wr_data : m0_wr_data;
    mem_wr_en    = (m0_gnt || m1_gnt) && (sel ? m1_wr_en : m0_wr_en);
    own_lock     = state == OWN1 ? m1_lock : m0_lock;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lock_cnt <= '0;
    end else if (state == IDLE) begin
      if (m0_gnt || m1_gnt) begin
        last_gnt <= sel;
        if (sel ? m1_lock : m0_lock) begin
          state    <= sel ? OWN1 : OWN0;
          lock_cnt <= CW'(1);
        end
      end
    end else if (!own_lock || lock_cnt == CW'(MAX_LOCK - 1)) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else lock_cnt <= lock_cnt + 1'b1;
  riscv_dmem_arb_rsp u_rsp0 (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (m0_gnt && !m0_wr_en),
    .mem_rd_data(mem_rd_data),
    .rd_valid   (m0_rd_valid),
    .rd_data    (m0_rd_data)
  );
  riscv_dmem_arb_rsp u_rsp1 (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (m1_gnt && !m1_wr_en),
    .mem_rd_data(mem_rd_data),
    .rd_valid   (m1_rd_valid),
    .rd_data    (m1_rd_data)
  );
endmodule
